// File: rtl/hqm_aw_fifo_pkg.sv
// Shared definitions for the 64x31 RF FIFO controller.
//   DEPTH/DWIDTH/AWIDTH/CWIDTH : RF geometry and count-field width
//   fifo_ptr_t                 : RF address / pointer type
//   fifo_status_t              : registered status bundle {count, full, empty}
//   ptr_inc()                  : pointer increment that wraps at DEPTH
package hqm_aw_fifo_pkg;

  localparam int DEPTH  = 64;
  localparam int DWIDTH = 31;
  localparam int AWIDTH = 6;
  localparam int CWIDTH = 7;

  typedef logic [AWIDTH-1:0] fifo_ptr_t;

  typedef struct packed {
    logic [CWIDTH-1:0] count;
    logic              full;
    logic              empty;
  } fifo_status_t;

  // DEPTH is a power of two, so natural overflow of the pointer is the wrap.
  function automatic fifo_ptr_t ptr_inc(input fifo_ptr_t p);
    return p + {{(AWIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/hqm_aw_fifo_prefetch_stage.sv
// Two-entry in-order skid register that absorbs the RF read latency.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_v / in_data      : RF read data returning (one cycle after mem_re)
//   out_v / out_data    : registered head of the stage
//   out_rdy             : consumer ready; out_v && out_rdy removes the head
//   cnt                 : entries currently held (0..2)
module hqm_aw_fifo_prefetch_stage
  import hqm_aw_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_v,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_v,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_rdy,
  output logic [1:0]        cnt
);

  logic [DWIDTH-1:0] r_d0;
  logic [DWIDTH-1:0] r_d1;
  logic [1:0]        r_cnt;
  logic              r_v;

  logic              w_pop;
  logic [1:0]        w_cnt_nxt;
  logic [DWIDTH-1:0] w_d0_nxt;
  logic [DWIDTH-1:0] w_d1_nxt;

  // Next-state of the two slots for every capture/pop combination.
  always_comb begin
    w_pop     = r_v && out_rdy;
    w_cnt_nxt = r_cnt;
    w_d0_nxt  = r_d0;
    w_d1_nxt  = r_d1;
    case ({in_v, w_pop})
      2'b01: begin
        w_d0_nxt  = r_d1;
        w_cnt_nxt = r_cnt - 2'd1;
      end
      2'b10: begin
        if (r_cnt == 2'd0) begin
          w_d0_nxt = in_data;
        end else begin
          w_d1_nxt = in_data;
        end
        w_cnt_nxt = r_cnt + 2'd1;
      end
      2'b11: begin
        // With one entry the incoming word becomes head directly: no bubble.
        if (r_cnt == 2'd1) begin
          w_d0_nxt = in_data;
        end else begin
          w_d0_nxt = r_d1;
          w_d1_nxt = in_data;
        end
      end
      default: begin
        w_cnt_nxt = r_cnt;
      end
    endcase
  end

  // Slot and valid registers; out_v is kept as its own flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d0  <= {DWIDTH{1'b0}};
      r_d1  <= {DWIDTH{1'b0}};
      r_cnt <= 2'd0;
      r_v   <= 1'b0;
    end else begin
      r_d0  <= w_d0_nxt;
      r_d1  <= w_d1_nxt;
      r_cnt <= w_cnt_nxt;
      r_v   <= (w_cnt_nxt != 2'd0);
    end
  end

  assign out_v    = r_v;
  assign out_data = r_d0;
  assign cnt      = r_cnt;

endmodule

// File: rtl/hqm_aw_rf_fifo_ctl_64x31.sv
// FIFO controller for one power-gated 64x31 2-port RF.
//   clk, rst_n                      : clock (also RF wclk/rclk), sync active-low reset
//   mem_pwr_ok                      : RF powered and out of isolation
//   push_v/push_data/push_rdy       : producer stream
//   pop_v/pop_data/pop_rdy          : consumer stream (pop_data from a flop)
//   mem_we/mem_waddr/mem_wdata      : RF write port
//   mem_re/mem_raddr/mem_rdata      : RF read port, rdata valid 1 clk after re
//   count/full/empty                : registered status
//   err_ovf                         : push attempted while full (1-clk pulse)
//   err_unf                         : sticky internal pop-underflow indication
module hqm_aw_rf_fifo_ctl_64x31
  import hqm_aw_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_pwr_ok,
  input  logic              push_v,
  input  logic [DWIDTH-1:0] push_data,
  output logic              push_rdy,
  output logic              pop_v,
  output logic [DWIDTH-1:0] pop_data,
  input  logic              pop_rdy,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_waddr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_re,
  output logic [AWIDTH-1:0] mem_raddr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [CWIDTH-1:0] count,
  output logic              full,
  output logic              empty,
  output logic              err_ovf,
  output logic              err_unf
);

  fifo_ptr_t         r_wptr;
  fifo_ptr_t         r_rptr;
  logic [CWIDTH-1:0] r_occ;
  logic              r_inflight;
  fifo_status_t      r_status;
  logic              r_err_unf;

  logic              w_push;
  logic              w_pop;
  logic              w_re;
  logic [1:0]        w_stage_cnt;
  logic [2:0]        w_stage_nxt;
  logic [CWIDTH-1:0] w_occ_nxt;
  logic [CWIDTH-1:0] w_count_nxt;

  hqm_aw_fifo_prefetch_stage u_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_v     (r_inflight),
    .in_data  (mem_rdata),
    .out_v    (pop_v),
    .out_data (pop_data),
    .out_rdy  (pop_rdy),
    .cnt      (w_stage_cnt)
  );

  // Push acceptance, RF write port, read issue and next-state status.
  always_comb begin
    // rst_n gating keeps the RF ports quiet while reset is held.
    push_rdy  = rst_n && mem_pwr_ok && !r_status.full;
    w_push    = push_v && push_rdy;
    mem_we    = w_push;
    mem_waddr = r_wptr;
    mem_wdata = push_data;
    err_ovf   = rst_n && push_v && !push_rdy && mem_pwr_ok && r_status.full;
    w_pop     = pop_v && pop_rdy;
    // Stage fill after this edge: the returning read lands, the pop leaves.
    // Counting the pop lets the stage refill every cycle under streaming.
    w_stage_nxt = {1'b0, w_stage_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_re      = rst_n && mem_pwr_ok && (r_occ != {CWIDTH{1'b0}}) && (w_stage_nxt < 3'd2);
    mem_re    = w_re;
    mem_raddr = r_rptr;
    w_occ_nxt   = r_occ + CWIDTH'(w_push) - CWIDTH'(w_re);
    w_count_nxt = w_occ_nxt + CWIDTH'(w_re) + CWIDTH'(w_stage_nxt);
  end

  // Pointers, occupancy, in-flight tracking and registered status/errors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr         <= {AWIDTH{1'b0}};
      r_rptr         <= {AWIDTH{1'b0}};
      r_occ          <= {CWIDTH{1'b0}};
      r_inflight     <= 1'b0;
      r_status.count <= {CWIDTH{1'b0}};
      r_status.full  <= 1'b0;
      r_status.empty <= 1'b1;
      r_err_unf      <= 1'b0;
    end else begin
      r_wptr         <= w_push ? ptr_inc(r_wptr) : r_wptr;
      r_rptr         <= w_re ? ptr_inc(r_rptr) : r_rptr;
      r_occ          <= w_occ_nxt;
      r_inflight     <= w_re;
      r_status.count <= w_count_nxt;
      r_status.full  <= (w_occ_nxt == CWIDTH'(DEPTH));
      r_status.empty <= (w_count_nxt == {CWIDTH{1'b0}});
      // pop_v mirrors the stage count; a pop with an empty stage means they diverged.
      r_err_unf      <= r_err_unf | (w_pop && (w_stage_cnt == 2'd0));
    end
  end

  assign count   = r_status.count;
  assign full    = r_status.full;
  assign empty   = r_status.empty;
  assign err_unf = r_err_unf;

endmodule

// File: tb/tb_hqm_aw_rf_fifo_ctl_64x31.sv
// Directed bench for hqm_aw_rf_fifo_ctl_64x31 with a behavioural 64x31 RF.
module tb_hqm_aw_rf_fifo_ctl_64x31;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_pwr_ok;
  logic        push_v;
  logic [30:0] push_data;
  logic        push_rdy;
  logic        pop_v;
  logic [30:0] pop_data;
  logic        pop_rdy;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [30:0] mem_wdata;
  logic        mem_re;
  logic [5:0]  mem_raddr;
  logic [30:0] mem_rdata = 31'd0;
  logic [6:0]  count;
  logic        full;
  logic        empty;
  logic        err_ovf;
  logic        err_unf;

  logic [30:0] rf [0:63];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hqm_aw_rf_fifo_ctl_64x31 dut (
    .clk(clk), .rst_n(rst_n), .mem_pwr_ok(mem_pwr_ok),
    .push_v(push_v), .push_data(push_data), .push_rdy(push_rdy),
    .pop_v(pop_v), .pop_data(pop_data), .pop_rdy(pop_rdy),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .count(count), .full(full), .empty(empty),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  // RF model: synchronous write, 1-cycle registered read, no bypass.
  always @(posedge clk) begin
    if (mem_we) rf[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= rf[mem_raddr];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are changed at posedge+1 and outputs sampled at posedge+2.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int popped;
    int pushed;
    bit done;
    logic [15:0] lfsr;
    logic [30:0] exp_q[$];
    logic [30:0] exp_d;

    // ---------------- reset, with push_v held high ----------------
    rst_n = 1'b0; mem_pwr_ok = 1'b1; push_v = 1'b1; push_data = 31'h7fff_ffff; pop_rdy = 1'b1;
    step(); step(); #1;
    check_val("rst_pop_v",    32'(pop_v),    32'd0);
    check_val("rst_count",    32'(count),    32'd0);
    check_val("rst_empty",    32'(empty),    32'd1);
    check_val("rst_full",     32'(full),     32'd0);
    check_val("rst_mem_we",   32'(mem_we),   32'd0);
    check_val("rst_mem_re",   32'(mem_re),   32'd0);
    check_val("rst_push_rdy", 32'(push_rdy), 32'd0);
    check_val("rst_err_ovf",  32'(err_ovf),  32'd0);
    check_val("rst_err_unf",  32'(err_unf),  32'd0);
    push_v = 1'b0; pop_rdy = 1'b0; rst_n = 1'b1;
    step();

    // ---------------- single push latency ----------------
    push_v = 1'b1; push_data = 31'h1234; #1;
    check_val("p1_we",    32'(mem_we),    32'd1);
    check_val("p1_waddr", 32'(mem_waddr), 32'd0);
    check_val("p1_wdata", 32'(mem_wdata), 32'h1234);
    step(); push_v = 1'b0; #1;
    check_val("p1_re",    32'(mem_re),    32'd1);
    check_val("p1_raddr", 32'(mem_raddr), 32'd0);
    check_val("p1_cnt1",  32'(count),     32'd1);
    step(); #1;
    check_val("p1_popv_n2", 32'(pop_v), 32'd0);
    step(); #1;
    check_val("p1_popv_n3", 32'(pop_v),    32'd1);
    check_val("p1_data",    32'(pop_data), 32'h1234);
    check_val("p1_empty0",  32'(empty),    32'd0);
    pop_rdy = 1'b1;
    step(); pop_rdy = 1'b0; #1;
    check_val("p1_after_pop", 32'(pop_v), 32'd0);
    check_val("p1_empty1",    32'(empty), 32'd1);
    check_val("p1_cnt0",      32'(count), 32'd0);
    step();

    // ---------------- fill to full with pop_rdy=0 ----------------
    acc = 0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      push_v = 1'b1; push_data = 31'(32'h100 + acc); #1;
      if (!push_rdy) done = 1'b1;
      else begin acc++; step(); end
    end
    check_val("full_accepted", 32'(acc),      32'd66);
    check_val("full_count",    32'(count),    32'd66);
    check_val("full_flag",     32'(full),     32'd1);
    check_val("full_push_rdy", 32'(push_rdy), 32'd0);
    check_val("full_err_ovf",  32'(err_ovf),  32'd1);
    check_val("full_no_we",    32'(mem_we),   32'd0);
    step(); push_v = 1'b0; #1;
    check_val("ovf_pulse_end", 32'(err_ovf), 32'd0);
    step();
    popped = 0;
    for (int c = 0; c < 300 && popped < 66; c++) begin
      pop_rdy = 1'b1; #1;
      if (pop_v) begin
        check_val("full_drain_data", 32'(pop_data), 32'h100 + 32'(popped));
        popped++;
      end
      step();
    end
    check_val("full_drain_n", 32'(popped), 32'd66);
    check_val("full_drain_empty", 32'(empty), 32'd1);

    // ---------------- 200-word stream, push+pop every clk ----------------
    pushed = 0; popped = 0;
    for (int c = 0; c < 400 && popped < 200; c++) begin
      push_v = (pushed < 200); push_data = 31'(32'h2000 + pushed); pop_rdy = 1'b1; #1;
      if (popped > 0) check_val("stream_nobubble", 32'(pop_v), 32'd1);
      if (pop_v && push_v) check_val("stream_count", 32'(count), 32'd3);
      if (push_v && push_rdy) pushed++;
      if (pop_v) begin
        check_val("stream_data", 32'(pop_data), 32'h2000 + 32'(popped));
        popped++;
      end
      step();
    end
    push_v = 1'b0;
    check_val("stream_n", 32'(popped), 32'd200);

    // ---------------- 1000 words with ~50% pop backpressure ----------------
    pushed = 0; popped = 0; lfsr = 16'hACE1;
    for (int c = 0; c < 6000 && popped < 1000; c++) begin
      push_v = (pushed < 1000); push_data = 31'(32'h40000 + pushed); pop_rdy = lfsr[0]; #1;
      if (push_v && push_rdy) begin exp_q.push_back(push_data); pushed++; end
      if (pop_v && pop_rdy) begin
        if (exp_q.size() == 0) check_val("rand_spurious_pop", 32'd1, 32'd0);
        else begin
          exp_d = exp_q.pop_front();
          check_val("rand_data", 32'(pop_data), 32'(exp_d));
        end
        popped++;
      end
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      step();
    end
    push_v = 1'b0; pop_rdy = 1'b0; #1;
    check_val("rand_n",       32'(popped),  32'd1000);
    check_val("rand_empty",   32'(empty),   32'd1);
    check_val("rand_err_unf", 32'(err_unf), 32'd0);
    step();

    // ---------------- power loss with 5 entries, 2 staged ----------------
    for (int i = 0; i < 5; i++) begin
      push_v = 1'b1; push_data = 31'(32'h5000 + i); step();
    end
    push_v = 1'b0;
    step(); step(); step(); step(); #1;
    check_val("pwr_count5", 32'(count), 32'd5);
    mem_pwr_ok = 1'b0; push_v = 1'b1; #1;
    check_val("pwr_push_rdy", 32'(push_rdy), 32'd0);
    check_val("pwr_no_we",    32'(mem_we),   32'd0);
    check_val("pwr_no_re",    32'(mem_re),   32'd0);
    check_val("pwr_no_ovf",   32'(err_ovf),  32'd0);
    step(); push_v = 1'b0; pop_rdy = 1'b1; #1;
    check_val("pwr_pop1_v", 32'(pop_v),    32'd1);
    check_val("pwr_pop1_d", 32'(pop_data), 32'h5000);
    check_val("pwr_pop1_re", 32'(mem_re),  32'd0);
    step(); #1;
    check_val("pwr_pop2_v", 32'(pop_v),    32'd1);
    check_val("pwr_pop2_d", 32'(pop_data), 32'h5001);
    check_val("pwr_pop2_re", 32'(mem_re),  32'd0);
    step(); #1;
    check_val("pwr_dry_v", 32'(pop_v), 32'd0);
    step(); step(); #1;
    check_val("pwr_dry_v2",  32'(pop_v), 32'd0);
    check_val("pwr_count3",  32'(count), 32'd3);
    mem_pwr_ok = 1'b1; #1;
    check_val("pwr_resume_re", 32'(mem_re), 32'd1);
    step();
    popped = 2;
    for (int c = 0; c < 50 && popped < 5; c++) begin
      pop_rdy = 1'b1; #1;
      if (pop_v) begin
        check_val("pwr_drain_data", 32'(pop_data), 32'h5000 + 32'(popped));
        popped++;
      end
      step();
    end
    check_val("pwr_drain_n", 32'(popped), 32'd5);
    pop_rdy = 1'b0;

    // ---------------- reset mid-stream with count=10 ----------------
    for (int i = 0; i < 10; i++) begin
      push_v = 1'b1; push_data = 31'(32'h6000 + i); step();
    end
    push_v = 1'b0;
    step(); step(); step(); #1;
    check_val("mrst_count10", 32'(count), 32'd10);
    rst_n = 1'b0;
    step(); rst_n = 1'b1; #1;
    check_val("mrst_count", 32'(count), 32'd0);
    check_val("mrst_pop_v", 32'(pop_v), 32'd0);
    check_val("mrst_empty", 32'(empty), 32'd1);
    push_v = 1'b1; push_data = 31'h77; #1;
    check_val("mrst_we",    32'(mem_we),    32'd1);
    check_val("mrst_waddr", 32'(mem_waddr), 32'd0);
    step(); push_v = 1'b0;
    step(); step(); #1;
    check_val("mrst_pop_v2",  32'(pop_v),    32'd1);
    check_val("mrst_pop_d2",  32'(pop_data), 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
